// File: rtl/register_file_dumper.sv
// register_file_dumper: debug-side reader for the pipeline register file.
// On start it freezes the core, lets in-flight writebacks drain, then walks
// registers FIRST_INDEX..LAST_INDEX through a dedicated read port and streams
// each value out over valid/ready, tagged with its index.
module register_file_dumper #(
  parameter int FIRST_INDEX  = 0,
  parameter int LAST_INDEX   = 31,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        freezePipeline,
  output logic        done,
  output logic [4:0]  readRegisterIndex,
  input  logic [31:0] readRegisterData,
  output logic        dumpValid,
  input  logic        dumpReady,
  output logic [31:0] dumpData,
  output logic [4:0]  dumpIndex,
  output logic        dumpLast
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [4:0] FIRST_IDX  = 5'(FIRST_INDEX);
  localparam logic [4:0] LAST_IDX   = 5'(LAST_INDEX);
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [4:0]  r_index;
  logic [3:0]  r_drain_cnt;
  logic [31:0] r_data;
  logic [4:0]  r_dump_idx;
  logic        r_last;

  logic w_start_ok;
  logic w_accept;
  logic w_at_last;

  // A handshake that coincides with abort does not count as delivered.
  assign w_start_ok = (r_state == S_IDLE) && start && !abort;
  assign w_accept   = (r_state == S_SEND) && dumpReady && !abort;
  assign w_at_last  = (r_index == LAST_IDX);

  // Next-state decode; abort wins over everything outside IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (abort)                   w_state_nxt = S_IDLE;
        else if (r_drain_cnt == 4'd0) w_state_nxt = S_READ;
      end
      S_READ:  w_state_nxt = abort ? S_IDLE : S_SEND;
      S_SEND: begin
        if (abort)         w_state_nxt = S_IDLE;
        else if (w_accept) w_state_nxt = w_at_last ? S_DONE : S_READ;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Drain counter and register walk index.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_drain_cnt <= 4'd0;
      r_index     <= 5'd0;
    end else begin
      if (w_start_ok) begin
        r_drain_cnt <= DRAIN_LOAD;
        r_index     <= FIRST_IDX;
      end else if (r_state == S_DRAIN && !abort && r_drain_cnt != 4'd0) begin
        r_drain_cnt <= r_drain_cnt - 4'd1;
      end
      // Never steps past LAST_IDX, so the 5-bit index cannot wrap.
      if (w_accept && !w_at_last) r_index <= r_index + 5'd1;
    end
  end

  // Capture the read-port word; held untouched through SEND until accepted.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_data     <= 32'd0;
      r_dump_idx <= 5'd0;
      r_last     <= 1'b0;
    end else if (r_state == S_READ && !abort) begin
      r_data     <= readRegisterData;
      r_dump_idx <= r_index;
      r_last     <= w_at_last;
    end
  end

  assign busy              = (r_state != S_IDLE);
  assign freezePipeline    = (r_state == S_DRAIN) || (r_state == S_READ) ||
                             (r_state == S_SEND);
  assign done              = (r_state == S_DONE) && !abort;
  assign dumpValid         = (r_state == S_SEND);
  assign readRegisterIndex = r_index;
  assign dumpData          = r_data;
  assign dumpIndex         = r_dump_idx;
  assign dumpLast          = r_last;

endmodule
